// File: rtl/start_btn_debounce.sv
// Start push-button conditioner: synchroniser, bounce filter, level output and press/release strobes.
// Optional long-hold strobe is built only when LONG_PRESS_EN is defined.
module start_btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_HIGH     = 1'b1,
    parameter int LONG_CYCLES     = 200000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             IDLE_RAW = ~ACTIVE_HIGH;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;

    // Sync flops reset to the raw not-pressed value so no false press follows reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= {SYNC_STAGES{IDLE_RAW}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign s = sync[SYNC_STAGES-1] ^ IDLE_RAW;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state       <= HELD;
                        cnt         <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    // A return to pressed before the count completes is a glitch; level stays high.
                    if (s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef LONG_PRESS_EN
    localparam int                LONG_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_ONE = LONG_W'(1);

    logic [LONG_W-1:0] long_cnt;

    // Counts only while staying in HELD; any exit clears it so a glitch restarts the hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (state == HELD && s) begin
                if (long_cnt != LONG_MAX) begin
                    long_cnt   <= long_cnt + LONG_ONE;
                    long_press <= ((long_cnt + LONG_ONE) == LONG_MAX);
                end
            end else begin
                long_cnt <= '0;
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_start_btn_debounce.sv
// Directed bench for start_btn_debounce: expected strobe cycles are queued at stimulus time
// and matched every cycle against an active-high and an active-low instance.
module tb_start_btn_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 16;
    localparam int LAT  = 1 + SYNC + DEB;  // from the drive point (#1 after edge c) to the output edge

    logic clk;
    logic rst;
    logic btn_raw;
    logic btn_raw_n;
    logic level_h, press_h, rel_h, long_h;
    logic level_l, press_l, rel_l, long_l;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   press_q[$];
    int   rel_q[$];
    int   long_q[$];
    logic lvl_exp = 1'b0;

    assign btn_raw_n = ~btn_raw;

    start_btn_debounce #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_HIGH(1'b1), .LONG_CYCLES(LONG)
    ) u_dut_h (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(level_h),
        .press_pulse(press_h), .release_pulse(rel_h), .long_press(long_h)
    );

    start_btn_debounce #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_HIGH(1'b0), .LONG_CYCLES(LONG)
    ) u_dut_l (
        .clk(clk), .rst(rst), .btn_raw(btn_raw_n), .btn_level(level_l),
        .press_pulse(press_l), .release_pulse(rel_l), .long_press(long_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: each queue holds the edge numbers at which that strobe must be high.
    always @(negedge clk) begin
        logic exp_p, exp_r, exp_lg;
        if (!rst) begin
            press_q.delete();
            rel_q.delete();
            long_q.delete();
            lvl_exp = 1'b0;
        end
        exp_p  = (press_q.size() > 0) && (press_q[0] == cyc);
        exp_r  = (rel_q.size() > 0) && (rel_q[0] == cyc);
        exp_lg = (long_q.size() > 0) && (long_q[0] == cyc);
        if (exp_p) begin
            lvl_exp = 1'b1;
            void'(press_q.pop_front());
        end
        if (exp_r) begin
            lvl_exp = 1'b0;
            void'(rel_q.pop_front());
        end
        if (exp_lg) void'(long_q.pop_front());
        check("press_hi", press_h, exp_p);
        check("release_hi", rel_h, exp_r);
        check("level_hi", level_h, lvl_exp);
        check("long_hi", long_h, exp_lg);
        check("press_lo", press_l, exp_p);
        check("release_lo", rel_l, exp_r);
        check("level_lo", level_l, lvl_exp);
        check("long_lo", long_l, exp_lg);
    end

    task automatic expect_press(input int hold);
        press_q.push_back(cyc + LAT);
`ifdef LONG_PRESS_EN
        // The hold must outlast the long count strictly before the release reaches the FSM.
        if (hold > LONG + DEB) long_q.push_back(cyc + LAT + LONG);
`endif
    endtask

    task automatic press_release(input int hold);
        btn_raw = 1'b1;
        expect_press(hold);
        step(hold);
        btn_raw = 1'b0;
        rel_q.push_back(cyc + LAT);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level_hi"}, level_h, 1'b0);
        check({tag, "_press_hi"}, press_h, 1'b0);
        check({tag, "_rel_hi"}, rel_h, 1'b0);
        check({tag, "_long_hi"}, long_h, 1'b0);
        check({tag, "_level_lo"}, level_l, 1'b0);
        check({tag, "_press_lo"}, press_l, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 1'b0;
        #2 rst  = 1'b0;
        step(3);
        check_all_zero("reset");
        rst = 1'b1;
        step(5);

        // Clean press then clean release.
        press_release(18);
        step(14);

        // Bounce never survives the stability window.
        btn_raw = 1'b1; step(3);
        btn_raw = 1'b0; step(1);
        btn_raw = 1'b1; step(3);
        btn_raw = 1'b0; step(14);

        // Short low glitch while held is absorbed.
        btn_raw = 1'b1;
        expect_press(10);
        step(10);
        btn_raw = 1'b0; step(2);
        btn_raw = 1'b1; step(10);
        btn_raw = 1'b0;
        rel_q.push_back(cyc + LAT);
        step(14);

        // Long hold.
        press_release(40);
        step(14);

        // Asynchronous reset while waiting to accept a press.
        btn_raw = 1'b1;
        expect_press(0);
        step(3);
        rst = 1'b0;
        #1;
        check_all_zero("rst_wait_hi");
        step(2);
        rst = 1'b1;
        expect_press(0);
        step(12);
        check("held_after_reset", level_h, 1'b1);

        // Asynchronous reset while held drops the level immediately.
        #1 rst = 1'b0;
        #1;
        check_all_zero("rst_held");
        step(1);
        btn_raw = 1'b0;
        rst = 1'b1;
        step(12);

        checks++;
        assert (press_q.size() + rel_q.size() + long_q.size() == 0) else begin
            errors++;
            $error("FAIL pending_expectations: observed=%0d expected=0",
                   press_q.size() + rel_q.size() + long_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
